pc_interrupt_controller: RTL and testbench
==========================================

Name: pc_interrupt_controller

Overview:
- Sequences the program counter's next-address selection for two prioritised interrupts (INT0 highest, INT1) and their returns.
- Latches interrupt request edges and tracks pending and in-service state, allowing INT0 to nest over INT1.
- On each FETCH it drives the PC next-address select and the return-address save strobes.
- Sits between the instruction decoder/interrupt sources and the program counter block.

Parameters:
- none

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- FETCH  input  1  fetch-cycle strobe; PC loads next address at the end of this cycle
- INT0_REQ  input  1  interrupt 0 request, level, synchronous to CLK
- INT1_REQ  input  1  interrupt 1 request, level, synchronous to CLK
- IE_SET  input  1  enable-interrupts strobe (EI instruction)
- IE_CLR  input  1  disable-interrupts strobe (DI instruction)
- RETI  input  1  return-from-interrupt, held by decoder through the FETCH that ends RETI
- PC_NEXTX  output  3  next-address select: 0=NEXT, 1=INTV0, 2=INTV1, 3=INTR0, 4=INTR1
- PC_LD_INT0X  output  1  save return address into INT0 return register
- PC_LD_INT1X  output  1  save return address into INT1 return register
- INT_ACK  output  2  one-cycle acknowledge per line, bit0=INT0
- PENDING  output  2  registered pending flags
- IN_SERVICE  output  2  registered in-service flags
- IE  output  1  registered global interrupt enable

Behaviour:
Reset:
- IE=0, PENDING=00, IN_SERVICE=00, edge-detect registers=0.
- Consequence: a request held high across reset registers as an edge in the first cycle after reset.

Request capture:
- PENDING[n] sets on a rising edge of INTn_REQ (REQ=1, previous sample 0).
- Once set it stays set until accepted, regardless of IE.
- Edge coinciding with acceptance of the same line: PENDING stays set.

Enable:
- IE_SET sets IE, IE_CLR clears it; both together means clear wins.

States, encoded by IN_SERVICE: IDLE(00), ISR1(10), ISR0(01), NEST(11, INT0 over INT1).

Outputs and transitions:
- PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X and INT_ACK are combinational from registered state plus FETCH/RETI.
- They are evaluated only while FETCH=1. With FETCH=0 they are NEXT/0/0/00 and no state changes.
- Priority within a FETCH cycle, highest first:
  1. RETI:
     - IN_SERVICE[0] set: PC_NEXTX=INTR0, clear IN_SERVICE[0] (NEST->ISR1, ISR0->IDLE).
     - Else IN_SERVICE[1] set: PC_NEXTX=INTR1, clear IN_SERVICE[1].
     - Else (spurious): PC_NEXTX=NEXT, no change.
     - No interrupt is accepted on a RETI fetch; a pending request is taken at the next FETCH.
  2. INT0 accept (IE & PENDING[0] & ~IN_SERVICE[0]):
     - PC_NEXTX=INTV0, PC_LD_INT0X=1, INT_ACK[0]=1.
     - Clear PENDING[0], set IN_SERVICE[0]. Allowed from IDLE or ISR1.
  3. INT1 accept (IE & PENDING[1] & IN_SERVICE==00):
     - PC_NEXTX=INTV1, PC_LD_INT1X=1, INT_ACK[1]=1.
     - Clear PENDING[1], set IN_SERVICE[1].
  4. Otherwise: PC_NEXTX=NEXT, strobes 0.
- At most one of PC_LD_INT0X and PC_LD_INT1X is high in any cycle; never high without FETCH.
- Latency: a request edge at cycle t sets PENDING at t+1. It is accepted at the first FETCH cycle at or after t+1 with the conditions met.

Reset mid-operation:
- Returns to IDLE with pending and in-service flags cleared.
- Outputs go to NEXT/0 in the cycle after RESET is sampled high.

Test Plan:
- RESET, IE_SET, pulse INT1_REQ, FETCH -> PC_NEXTX=2, PC_LD_INT1X=1, INT_ACK=10; next cycle IN_SERVICE=10, PENDING=00.
- In ISR1, pulse INT0_REQ then FETCH -> PC_NEXTX=1, PC_LD_INT0X=1, IN_SERVICE=11. RETI+FETCH -> PC_NEXTX=3, IN_SERVICE=10. RETI+FETCH -> PC_NEXTX=4, IN_SERVICE=00.
- Both requests edge in the same cycle with IE=1, FETCH -> INT0 first (PC_NEXTX=1), PENDING=10. INT1 is blocked until INT0's RETI, then taken on the following FETCH (PC_NEXTX=2).
- IE=0, pulse INT0_REQ, 3 FETCHes -> PC_NEXTX=0 each, PENDING=01. IE_SET and IE_CLR together -> IE stays 0. IE_SET then FETCH -> PC_NEXTX=1.
- In ISR0 with PENDING[1]=1, RETI+FETCH -> PC_NEXTX=3, no accept that cycle. Next FETCH -> PC_NEXTX=2. RETI in IDLE -> PC_NEXTX=0, state unchanged.
- INT0_REQ held high through RESET, IE_SET -> PENDING=01 after the first post-reset cycle. Assert RESET while in NEST -> IN_SERVICE=00, PENDING=00, IE=0 next cycle.

Source files
------------

// File: rtl/pc_interrupt_controller.sv
// Two-level prioritised interrupt sequencer for the program counter: latches request
// edges, tracks pending/in-service state and drives next-address select on each FETCH.
module pc_interrupt_controller (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FETCH,
  input  logic       INT0_REQ,
  input  logic       INT1_REQ,
  input  logic       IE_SET,
  input  logic       IE_CLR,
  input  logic       RETI,
  output logic [2:0] PC_NEXTX,
  output logic       PC_LD_INT0X,
  output logic       PC_LD_INT1X,
  output logic [1:0] INT_ACK,
  output logic [1:0] PENDING,
  output logic [1:0] IN_SERVICE,
  output logic       IE
);

  localparam logic [2:0] SEL_NEXT  = 3'd0;
  localparam logic [2:0] SEL_INTV0 = 3'd1;
  localparam logic [2:0] SEL_INTV1 = 3'd2;
  localparam logic [2:0] SEL_INTR0 = 3'd3;
  localparam logic [2:0] SEL_INTR1 = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'b00;

  logic [1:0] req_q;
  logic [1:0] req_edge;
  logic [1:0] pend_clr;
  logic [1:0] svc_set;
  logic [1:0] svc_clr;

  assign req_edge = {INT1_REQ, INT0_REQ} & ~req_q;

  // Decision stage: everything below depends only on registered state plus FETCH/RETI.
  always_comb begin
    PC_NEXTX    = SEL_NEXT;
    PC_LD_INT0X = 1'b0;
    PC_LD_INT1X = 1'b0;
    INT_ACK     = 2'b00;
    pend_clr    = 2'b00;
    svc_set     = 2'b00;
    svc_clr     = 2'b00;
    if (FETCH) begin
      if (RETI) begin
        // INT0 can only nest over INT1, so an active INT0 is always the innermost level.
        if (IN_SERVICE[0]) begin
          PC_NEXTX   = SEL_INTR0;
          svc_clr[0] = 1'b1;
        end else if (IN_SERVICE[1]) begin
          PC_NEXTX   = SEL_INTR1;
          svc_clr[1] = 1'b1;
        end
      end else if (IE && PENDING[0] && !IN_SERVICE[0]) begin
        PC_NEXTX    = SEL_INTV0;
        PC_LD_INT0X = 1'b1;
        INT_ACK[0]  = 1'b1;
        pend_clr[0] = 1'b1;
        svc_set[0]  = 1'b1;
      end else if (IE && PENDING[1] && (IN_SERVICE == ST_IDLE)) begin
        PC_NEXTX    = SEL_INTV1;
        PC_LD_INT1X = 1'b1;
        INT_ACK[1]  = 1'b1;
        pend_clr[1] = 1'b1;
        svc_set[1]  = 1'b1;
      end
    end
  end

  // State stage: a new edge on a line being accepted in the same cycle re-arms PENDING.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_q      <= 2'b00;
      PENDING    <= 2'b00;
      IN_SERVICE <= ST_IDLE;
      IE         <= 1'b0;
    end else begin
      req_q      <= {INT1_REQ, INT0_REQ};
      PENDING    <= (PENDING & ~pend_clr) | req_edge;
      IN_SERVICE <= (IN_SERVICE & ~svc_clr) | svc_set;
      if (IE_CLR)      IE <= 1'b0;
      else if (IE_SET) IE <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_interrupt_controller.sv
// Bench for pc_interrupt_controller: directed scenarios then random traffic, each cycle
// compared against a stack-based model of interrupt nesting.
module tb_pc_interrupt_controller;

  logic       clk;
  logic       RESET, FETCH, INT0_REQ, INT1_REQ, IE_SET, IE_CLR, RETI;
  logic [2:0] PC_NEXTX;
  logic       PC_LD_INT0X, PC_LD_INT1X;
  logic [1:0] INT_ACK, PENDING, IN_SERVICE;
  logic       IE;

  pc_interrupt_controller dut (
    .CLK(clk), .RESET(RESET), .FETCH(FETCH), .INT0_REQ(INT0_REQ), .INT1_REQ(INT1_REQ),
    .IE_SET(IE_SET), .IE_CLR(IE_CLR), .RETI(RETI), .PC_NEXTX(PC_NEXTX),
    .PC_LD_INT0X(PC_LD_INT0X), .PC_LD_INT1X(PC_LD_INT1X), .INT_ACK(INT_ACK),
    .PENDING(PENDING), .IN_SERVICE(IN_SERVICE), .IE(IE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: global enable, pending flags, a stack of lines in service.
  bit       m_known = 0;
  bit       m_ie;
  bit [1:0] m_pend;
  bit [1:0] m_prev;
  int       stk[$];

  logic [2:0] obs_nextx;
  logic       obs_ld0, obs_ld1;
  logic [1:0] obs_ack;

  function automatic bit [1:0] svc_bits();
    bit [1:0] b = 2'b00;
    foreach (stk[i]) b[stk[i]] = 1'b1;
    return b;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit f, input bit rt, input bit r0, input bit r1,
                     input bit es, input bit ec, input bit rs);
    int       act;
    bit [2:0] e_nx;
    bit [1:0] edges;
    FETCH = f; RETI = rt; INT0_REQ = r0; INT1_REQ = r1;
    IE_SET = es; IE_CLR = ec; RESET = rs;
    act  = 0;
    e_nx = 3'd0;
    if (f) begin
      if (rt) begin
        if (stk.size() > 0) begin
          e_nx = (stk[$] == 0) ? 3'd3 : 3'd4;
          act  = 1;
        end
      end else if (m_ie && m_pend[0] && !svc_bits()[0]) begin
        e_nx = 3'd1; act = 2;
      end else if (m_ie && m_pend[1] && stk.size() == 0) begin
        e_nx = 3'd2; act = 3;
      end
    end
    @(negedge clk);
    obs_nextx = PC_NEXTX; obs_ld0 = PC_LD_INT0X; obs_ld1 = PC_LD_INT1X; obs_ack = INT_ACK;
    if (m_known) begin
      check("pc_nextx",   8'(PC_NEXTX),    8'(e_nx));
      check("ld_int0",    8'(PC_LD_INT0X), 8'(act == 2));
      check("ld_int1",    8'(PC_LD_INT1X), 8'(act == 3));
      check("int_ack",    8'(INT_ACK),     8'({act == 3, act == 2}));
      check("pending",    8'(PENDING),     8'(m_pend));
      check("in_service", 8'(IN_SERVICE),  8'(svc_bits()));
      check("ie",         8'(IE),          8'(m_ie));
    end
    @(posedge clk);
    if (rs) begin
      m_known = 1; m_ie = 0; m_pend = 2'b00; m_prev = 2'b00; stk.delete();
    end else begin
      edges = {r1, r0} & ~m_prev;
      case (act)
        1: void'(stk.pop_back());
        2: begin m_pend[0] = 1'b0; stk.push_back(0); end
        3: begin m_pend[1] = 1'b0; stk.push_back(1); end
        default: ;
      endcase
      m_pend = m_pend | edges;
      m_prev = {r1, r0};
      if (ec)      m_ie = 1'b0;
      else if (es) m_ie = 1'b1;
    end
    #1;
  endtask

  initial begin
    RESET = 1'b1; FETCH = 0; RETI = 0; INT0_REQ = 0; INT1_REQ = 0; IE_SET = 0; IE_CLR = 0;

    // Reset state
    cyc(0,0,0,0,0,0,1);
    check("rst_ie", 8'(IE), 8'h0);
    check("rst_pending", 8'(PENDING), 8'h0);
    check("rst_in_service", 8'(IN_SERVICE), 8'h0);

    // INT1 accept from IDLE
    cyc(0,0,0,0,1,0,0);
    cyc(0,0,0,1,0,0,0);
    cyc(1,0,0,0,0,0,0);
    check("t1_nextx", 8'(obs_nextx), 8'd2);
    check("t1_ld1", 8'(obs_ld1), 8'd1);
    check("t1_ack", 8'(obs_ack), 8'b10);
    check("t1_is", 8'(IN_SERVICE), 8'b10);
    check("t1_pend", 8'(PENDING), 8'b00);

    // Nest INT0 over INT1 and unwind
    cyc(0,0,1,0,0,0,0);
    cyc(1,0,0,0,0,0,0);
    check("t2_nextx", 8'(obs_nextx), 8'd1);
    check("t2_ld0", 8'(obs_ld0), 8'd1);
    check("t2_is", 8'(IN_SERVICE), 8'b11);
    cyc(1,1,0,0,0,0,0);
    check("t2_reti0", 8'(obs_nextx), 8'd3);
    check("t2_is_after0", 8'(IN_SERVICE), 8'b10);
    cyc(1,1,0,0,0,0,0);
    check("t2_reti1", 8'(obs_nextx), 8'd4);
    check("t2_is_after1", 8'(IN_SERVICE), 8'b00);

    // Simultaneous edges: INT0 wins, INT1 waits for its RETI
    cyc(0,0,1,1,0,0,0);
    cyc(1,0,0,0,0,0,0);
    check("t3_nextx", 8'(obs_nextx), 8'd1);
    check("t3_pend", 8'(PENDING), 8'b10);
    cyc(1,0,0,0,0,0,0);
    check("t3_blocked", 8'(obs_nextx), 8'd0);
    cyc(1,1,0,0,0,0,0);
    check("t3_reti", 8'(obs_nextx), 8'd3);
    cyc(1,0,0,0,0,0,0);
    check("t3_int1", 8'(obs_nextx), 8'd2);
    cyc(1,1,0,0,0,0,0);

    // Disabled interrupts keep the request pending; clear beats set
    cyc(0,0,0,0,0,1,0);
    cyc(0,0,1,0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      cyc(1,0,0,0,0,0,0);
      check("t4_masked", 8'(obs_nextx), 8'd0);
    end
    check("t4_pend", 8'(PENDING), 8'b01);
    cyc(0,0,0,0,1,1,0);
    check("t4_ie_clr_wins", 8'(IE), 8'd0);
    cyc(0,0,0,0,1,0,0);
    cyc(1,0,0,0,0,0,0);
    check("t4_take", 8'(obs_nextx), 8'd1);

    // RETI fetch never accepts; spurious RETI in IDLE
    cyc(0,0,0,1,0,0,0);
    cyc(1,0,0,0,0,0,0);
    check("t5_isr0_blocks1", 8'(obs_nextx), 8'd0);
    cyc(1,1,0,0,0,0,0);
    check("t5_reti", 8'(obs_nextx), 8'd3);
    check("t5_no_ack", 8'(obs_ack), 8'b00);
    cyc(1,0,0,0,0,0,0);
    check("t5_int1", 8'(obs_nextx), 8'd2);
    cyc(1,1,0,0,0,0,0);
    cyc(1,1,0,0,0,0,0);
    check("t5_spurious", 8'(obs_nextx), 8'd0);
    check("t5_idle", 8'(IN_SERVICE), 8'b00);

    // Request held through reset; reset out of NEST
    cyc(0,0,1,0,0,0,1);
    cyc(0,0,1,0,1,0,0);
    check("t6_held_edge", 8'(PENDING), 8'b01);
    cyc(1,0,0,0,0,0,0);
    cyc(1,1,0,0,0,0,0);
    cyc(0,0,0,1,0,0,0);
    cyc(1,0,0,0,0,0,0);
    cyc(0,0,1,0,0,0,0);
    cyc(1,0,0,0,0,0,0);
    check("t6_nest", 8'(IN_SERVICE), 8'b11);
    cyc(0,0,0,1,0,0,1);
    check("t6_rst_is", 8'(IN_SERVICE), 8'b00);
    check("t6_rst_pend", 8'(PENDING), 8'b00);
    check("t6_rst_ie", 8'(IE), 8'd0);
    cyc(1,1,0,0,0,0,0);
    check("t6_rst_next", 8'(obs_nextx), 8'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 96) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
